shift_rows_stage: RTL and testbench

Registered, elastic ShiftRows stage that sits directly downstream of the byte-substitution stage in the AES encrypt round datapath. It accepts the 128-bit substituted state under a valid/ready handshake and cyclically left-shifts state row r by r byte positions. It buffers results in a small FIFO and presents them to the MixColumns/AddRoundKey side with its own valid/ready handshake. A per-block final-round tag travels alongside the data, so downstream logic can bypass MixColumns in round 10.

---
 rtl/shift_rows_stage.sv | 108 ++++++++++
 tb/tb_shift_rows_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/shift_rows_stage.sv
// AES ShiftRows pipeline stage: applies the row rotation on the write path and
// buffers shifted blocks, each with its final-round tag, in a small elastic FIFO.
module shift_rows_stage #(
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            shiftRows_valid_in,
  input  logic [DATA_WIDTH-1:0]           shiftRows_data_in,
  input  logic                            shiftRows_last_in,
  output logic                            shiftRows_ready_out,
  output logic                            shiftRows_valid_out,
  output logic [DATA_WIDTH-1:0]           shiftRows_data_out,
  output logic                            shiftRows_last_out,
  input  logic                            shiftRows_ready_in,
  output logic [$clog2(FIFO_DEPTH):0]     shiftRows_count_out
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W = PTR_W + 1;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t             mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [COUNT_W-1:0] count;
  logic               valid_q;
  logic               ready_q;
  entry_t             head_q;

  logic [DATA_WIDTH-1:0] shifted_c;
  entry_t                in_entry_c;
  entry_t                head_nxt_c;
  logic                  push_c;
  logic                  pop_c;
  logic [PTR_W-1:0]      wr_ptr_nxt_c;
  logic [PTR_W-1:0]      rd_ptr_nxt_c;
  logic [COUNT_W-1:0]    count_nxt_c;

  // Column-major state: byte k is row k%4, column k/4; row r rotates left by r.
  always_comb begin
    shifted_c = '0;
    for (int k = 0; k < 16; k++) begin
      shifted_c[DATA_WIDTH-1-8*k -: 8] =
        shiftRows_data_in[DATA_WIDTH-1-8*(4*(((k/4) + (k%4)) % 4) + (k%4)) -: 8];
    end
  end

  always_comb begin
    in_entry_c      = '0;
    in_entry_c.data = shifted_c;
    in_entry_c.last = shiftRows_last_in;
  end

  assign push_c = shiftRows_valid_in && ready_q;
  assign pop_c  = valid_q && shiftRows_ready_in;

  always_comb begin
    wr_ptr_nxt_c = wr_ptr;
    rd_ptr_nxt_c = rd_ptr;
    count_nxt_c  = count;
    if (push_c) wr_ptr_nxt_c = wr_ptr + PTR_W'(1);
    if (pop_c)  rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
    case ({push_c, pop_c})
      2'b10:   count_nxt_c = count + COUNT_W'(1);
      2'b01:   count_nxt_c = count - COUNT_W'(1);
      default: count_nxt_c = count;
    endcase
  end

  // Next head is the post-update mem[rd_ptr]; bypass the entry being written into it.
  always_comb begin
    head_nxt_c = mem[rd_ptr_nxt_c];
    if (push_c && (wr_ptr == rd_ptr_nxt_c)) head_nxt_c = in_entry_c;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      head_q  <= '0;
    end else begin
      if (push_c) mem[wr_ptr] <= in_entry_c;
      wr_ptr  <= wr_ptr_nxt_c;
      rd_ptr  <= rd_ptr_nxt_c;
      count   <= count_nxt_c;
      valid_q <= (count_nxt_c != '0);
      ready_q <= (count_nxt_c != COUNT_W'(FIFO_DEPTH));
      head_q  <= head_nxt_c;
    end
  end

  assign shiftRows_ready_out = ready_q;
  assign shiftRows_valid_out = valid_q;
  assign shiftRows_data_out  = head_q.data;
  assign shiftRows_last_out  = head_q.last;
  assign shiftRows_count_out = count;

endmodule

// File: tb/tb_shift_rows_stage.sv
// Randomized self-checking bench for shift_rows_stage against a queue-based
// reference model of the ShiftRows FIFO.
module tb_shift_rows_stage;

  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid_in = 1'b0;
  logic [127:0] data_in = '0;
  logic         last_in = 1'b0;
  logic         ready_out;
  logic         valid_out;
  logic [127:0] data_out;
  logic         last_out;
  logic         ready_in = 1'b0;
  logic [1:0]   count_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [128:0] model_q[$];

  shift_rows_stage #(.DATA_WIDTH(128), .FIFO_DEPTH(DEPTH)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .shiftRows_valid_in  (valid_in),
    .shiftRows_data_in   (data_in),
    .shiftRows_last_in   (last_in),
    .shiftRows_ready_out (ready_out),
    .shiftRows_valid_out (valid_out),
    .shiftRows_data_out  (data_out),
    .shiftRows_last_out  (last_out),
    .shiftRows_ready_in  (ready_in),
    .shiftRows_count_out (count_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [128:0] obs, input logic [128:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // State as a 4x4 matrix: load column-major, rotate each row left by its index.
  function automatic logic [127:0] ref_shift(input logic [127:0] s);
    logic [7:0]   m [4][4];
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = s[127-8*(4*c+r) -: 8];
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = m[r][(c+r)%4];
    return o;
  endfunction

  // Apply one cycle of inputs, advance the model, then compare every output.
  task automatic do_cycle(input logic r, input logic v, input logic [127:0] d,
                          input logic l, input logic rdy, output logic accepted);
    logic push, pop;
    rst = r; valid_in = v; data_in = d; last_in = l; ready_in = rdy;
    push = v && (model_q.size() != DEPTH);
    pop  = rdy && (model_q.size() != 0);
    accepted = push && !r;
    @(posedge clk);
    #1;
    if (r) model_q.delete();
    else begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back({l, ref_shift(d)});
    end
    check("valid_out", 129'(valid_out), 129'(model_q.size() != 0));
    check("ready_out", 129'(ready_out), 129'(model_q.size() != DEPTH));
    check("count_out", 129'(count_out), 129'(model_q.size()));
    check("count_max", 129'(count_out <= 2'd2), 129'(1));
    if (model_q.size() != 0) begin
      check("data_out", 129'(data_out), 129'(model_q[0][127:0]));
      check("last_out", 129'(last_out), 129'(model_q[0][128]));
    end
  endtask

  initial begin
    logic         acc;
    logic [127:0] blk;
    logic         blk_last;
    int           n_acc;
    int           iter;

    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      do_cycle(1'b1, 1'($urandom), {$urandom, $urandom, $urandom, $urandom},
               1'($urandom), 1'($urandom), acc);
    check("rst_data", 129'(data_out), 129'(0));
    check("rst_last", 129'(last_out), 129'(0));

    // FIPS-197 vector
    do_cycle(1'b0, 1'b1, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 1'b1, acc);
    check("fips_valid", 129'(valid_out), 129'(1));
    check("fips_data", 129'(data_out), 129'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    check("fips_count", 129'(count_out), 129'(1));
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Backpressure: A, B fill the FIFO, C held until a slot frees
    do_cycle(1'b0, 1'b1, 128'h000102030405060708090a0b0c0d0e0f, 1'b0, 1'b0, acc);
    do_cycle(1'b0, 1'b1, 128'h101112131415161718191a1b1c1d1e1f, 1'b1, 1'b0, acc);
    do_cycle(1'b0, 1'b1, 128'h202122232425262728292a2b2c2d2e2f, 1'b0, 1'b0, acc);
    check("bp_c_held", 129'(acc), 129'(0));
    check("bp_full_cnt", 129'(count_out), 129'(2));
    check("bp_head_a", 129'(data_out), 129'(ref_shift(128'h000102030405060708090a0b0c0d0e0f)));
    do_cycle(1'b0, 1'b1, 128'h202122232425262728292a2b2c2d2e2f, 1'b0, 1'b1, acc);
    check("bp_c_wait", 129'(acc), 129'(0));
    check("bp_head_b", 129'(data_out), 129'(ref_shift(128'h101112131415161718191a1b1c1d1e1f)));
    do_cycle(1'b0, 1'b1, 128'h202122232425262728292a2b2c2d2e2f, 1'b0, 1'b1, acc);
    check("bp_c_acc", 129'(acc), 129'(1));
    check("bp_head_c", 129'(data_out), 129'(ref_shift(128'h202122232425262728292a2b2c2d2e2f)));
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Streaming 10 blocks through the pointer wrap
    for (int i = 1; i <= 10; i++) begin
      do_cycle(1'b0, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'(i == 10), 1'b1, acc);
      check("stream_cnt", 129'(count_out), 129'(1));
      check("stream_last", 129'(last_out), 129'(i == 10));
    end
    do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);

    // Random traffic: 200 blocks, upstream holds each block until accepted
    n_acc = 0;
    iter = 0;
    blk = {$urandom, $urandom, $urandom, $urandom};
    blk_last = 1'($urandom);
    while (n_acc < 200 && iter < 3000) begin
      do_cycle(1'b0, ($urandom_range(3) != 0), blk, blk_last, 1'($urandom), acc);
      if (acc) begin
        n_acc++;
        blk = {$urandom, $urandom, $urandom, $urandom};
        blk_last = 1'($urandom);
      end
      iter++;
    end
    check("rand_accepted", 129'(n_acc), 129'(200));
    iter = 0;
    while (model_q.size() != 0 && iter < 10) begin
      do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
      iter++;
    end
    check("rand_drained", 129'(count_out), 129'(0));

    // Reset mid-operation discards buffered blocks
    do_cycle(1'b0, 1'b1, 128'hdeadbeef00112233445566778899aabb, 1'b1, 1'b0, acc);
    do_cycle(1'b0, 1'b1, 128'hcafef00d00112233445566778899aabb, 1'b0, 1'b0, acc);
    check("mid_full", 129'(count_out), 129'(2));
    do_cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, acc);
    check("mid_rst_cnt", 129'(count_out), 129'(0));
    check("mid_rst_valid", 129'(valid_out), 129'(0));
    for (int i = 0; i < 3; i++) begin
      do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, acc);
      check("mid_no_stale", 129'(valid_out), 129'(0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
